up_conv_stream_arbiter: RTL and testbench
=========================================

Name: up_conv_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one up-width converter input between NUM_PORTS narrow AXI-Stream-style sources.
- Sits directly in front of the up-width converter. Its dout/dout_ready pair connects to the converter's din/din_ready.
- A grant is held from the first beat of a packet until its last beat, so the converter never packs beats from two sources into one wide word.
- The output is registered; full throughput is sustained while the grant is held.

Parameters:
- NUM_PORTS, 4, number of requesters. Legal range is 2..16; any other value forces an elaboration error.
- DATA_WIDTH, 8, per-beat data width. Must be a multiple of 8 and at least 8; any other value forces an elaboration error.
- GRANT_WIDTH, clog2(NUM_PORTS), derived localparam; not user-settable.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable; when low, all state is frozen and every ready output is 0.
- din  in  NUM_PORTS*DATA_WIDTH  flattened source data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- din_strb  in  NUM_PORTS*DATA_WIDTH/8  flattened byte strobes, sliced the same way as din.
- din_last  in  NUM_PORTS  end-of-packet flag per port.
- din_valid  in  NUM_PORTS  valid per port.
- din_ready  out  NUM_PORTS  ready per port; one-hot or zero.
- dout  out  DATA_WIDTH  data to the converter.
- dout_strb  out  DATA_WIDTH/8  strobes to the converter.
- dout_last  out  1  end-of-packet to the converter.
- dout_valid  out  1  valid to the converter.
- dout_ready  in  1  ready from the converter.
- grant  out  GRANT_WIDTH  index of the current or most recent owner.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (rst=1 at a clock edge):
  - dout, dout_strb, dout_last, dout_valid, din_ready, busy all go to 0.
  - grant goes to NUM_PORTS-1, so port 0 has first priority.
  - State goes to IDLE.
  - Reset mid-packet discards any partial packet. No recovery is attempted; the source must restart the packet.
- State IDLE:
  - din_ready is all 0.
  - If cen is high and any din_valid is high, pick the first port with valid set, searching cyclically from grant+1.
  - Register the pick into grant, set busy, and move to GRANT.
  - This costs one arbitration bubble per packet.
- State GRANT:
  - din_ready[grant] = cen & (~dout_valid | dout_ready). All other din_ready bits are 0.
  - On a source handshake (din_valid[grant] & din_ready[grant]), load dout/dout_strb/dout_last from the granted slice and set dout_valid.
  - On an output handshake (dout_valid & dout_ready) with no simultaneous load, clear dout_valid. dout/strb/last keep their values.
  - A simultaneous output handshake and load makes dout_valid stay 1 with the new beat. Zero-bubble streaming is required.
  - A loaded beat with din_last=1 moves the block to IDLE and clears busy. grant keeps the last owner and seeds the next search.
- Latency:
  - Request to din_ready: 1 cycle.
  - Accepted beat to dout_valid: 1 cycle.
  - Back-to-back packets from different ports incur exactly 1 idle cycle on the source side.
- Boundary conditions:
  - Granted source drops valid mid-packet: the grant is held; other ports wait.
  - Single-beat packet (last on the first beat): return to IDLE after one beat.
  - The wrap search from port NUM_PORTS-1 continues to port 0.
  - The converter holds dout_ready=0 indefinitely: the output register holds its beat and din_ready stays 0.
  - cen=0 in any state: no state, grant, or output register changes; din_ready=0.
  - Requests arriving while in GRANT are only considered at the next IDLE.

Optional Feature:
- Macro: UP_CONV_ARB_ID_EN.
- When defined:
  - Adds output dout_id [GRANT_WIDTH], registered alongside dout with the owner index of the beat. Reset value 0.
  - Lets downstream logic demultiplex after the converter.
- When undefined: the port and its register are absent. Behaviour is otherwise identical.

Decomposition:
- Shared constants file (width_conv_defs):
  - clog2 function.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Parameter-check macro, reused by the converter blocks.
- Sub-module rr_pick: purely combinational. Inputs are a request vector and the last grant; outputs are the next index and a found flag. It is reusable by the later down-converter arbiter.
- The top level holds the FSM, the output register and the muxing.

Test Plan:
- Reset, then assert din_valid=4'b0001 with a 3-beat packet 0x11,0x22,0x33 (last on 0x33) and dout_ready=1.
  - grant=0 one cycle after the request.
  - dout shows 0x11,0x22,0x33 on consecutive cycles.
  - dout_last coincides with 0x33.
  - busy falls the cycle after the last beat is accepted.
- All four ports continuously valid with 2-beat packets.
  - Grant order is 0,1,2,3,0.
  - No beats are interleaved between ports.
  - Exactly one idle cycle between packets.
- dout_ready held low for 5 cycles mid-packet.
  - dout holds its value.
  - din_ready[grant]=0 during the stall.
  - No beat is lost or duplicated when ready returns.
- Port 2 granted; after beat 1, port 2 drops valid for 3 cycles while port 1 is valid.
  - grant stays 2 and din_ready[1]=0 throughout.
  - The packet completes before port 1 is served.
- cen=0 pulsed for 2 cycles mid-packet.
  - All outputs are frozen and din_ready=0.
  - Resumes with no loss.
- rst asserted for one cycle mid-packet on port 3.
  - All outputs go to 0, grant=3 (NUM_PORTS-1), state IDLE.
  - The next request from port 0 is granted first.

Source files
------------

// File: rtl/width_conv_defs.sv
// rtl/width_conv_defs.sv - shared clog2, state encodings and parameter check for the width converters
// Compile first: the parameter-check macro is used by the files that follow.
`ifndef WIDTH_CONV_DEFS_SV
`define WIDTH_CONV_DEFS_SV

`define WIDTH_CONV_PARAM_CHECK(cond, blk) \
  if (!(cond)) begin : blk \
    $error("width_conv: illegal parameter value"); \
  end

package width_conv_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/up_conv_stream_arbiter_rr_pick.sv
// rtl/up_conv_stream_arbiter_rr_pick.sv - combinational round-robin picker
// Returns the first requester found searching cyclically from last_i+1.
module rr_pick
  import width_conv_defs::*;
#(
  parameter  int NUM_PORTS   = 4,
  localparam int GRANT_WIDTH = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]   req_i,
  input  logic [GRANT_WIDTH-1:0] last_i,
  output logic [GRANT_WIDTH-1:0] pick_o,
  output logic                   found_o
);

  logic [GRANT_WIDTH-1:0] cand;

  always_comb begin
    pick_o  = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = GRANT_WIDTH'((int'(last_i) + i) % NUM_PORTS);
      if (!found_o && req_i[cand]) begin
        pick_o  = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/up_conv_stream_arbiter.sv
// rtl/up_conv_stream_arbiter.sv - packet-granular round-robin arbiter feeding an up-width converter
// Optional macro UP_CONV_ARB_ID_EN adds dout_id, the owner index of each output beat.
module up_conv_stream_arbiter
  import width_conv_defs::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int DATA_WIDTH  = 8,
  localparam int GRANT_WIDTH = clog2(NUM_PORTS),
  localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cen,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  din,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0]  din_strb,
  input  logic [NUM_PORTS-1:0]             din_last,
  input  logic [NUM_PORTS-1:0]             din_valid,
  output logic [NUM_PORTS-1:0]             din_ready,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [STRB_WIDTH-1:0]            dout_strb,
  output logic                             dout_last,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [GRANT_WIDTH-1:0]           grant,
`ifdef UP_CONV_ARB_ID_EN
  output logic [GRANT_WIDTH-1:0]           dout_id,
`endif
  output logic                             busy
);

  `WIDTH_CONV_PARAM_CHECK(NUM_PORTS >= 2 && NUM_PORTS <= 16, g_chk_num_ports)
  `WIDTH_CONV_PARAM_CHECK(DATA_WIDTH >= 8 && (DATA_WIDTH % 8) == 0, g_chk_data_width)

  arb_state_e             state_q, state_d;
  logic [GRANT_WIDTH-1:0] grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic [STRB_WIDTH-1:0]  strb_q, strb_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
`ifdef UP_CONV_ARB_ID_EN
  logic [GRANT_WIDTH-1:0] id_q, id_d;
`endif

  logic [GRANT_WIDTH-1:0] pick;
  logic                   found;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [STRB_WIDTH-1:0]  sel_strb;
  logic                   sel_last;
  logic                   sel_valid;
  logic                   out_free;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
    .req_i   (din_valid),
    .last_i  (grant_q),
    .pick_o  (pick),
    .found_o (found)
  );

  always_comb begin
    sel_data  = '0;
    sel_strb  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GRANT_WIDTH'(i)) begin
        sel_data  = din[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = din_strb[i*STRB_WIDTH +: STRB_WIDTH];
        sel_last  = din_last[i];
        sel_valid = din_valid[i];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = ~valid_q | dout_ready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    dout_d    = dout_q;
    strb_d    = strb_q;
    last_d    = last_q;
    valid_d   = valid_q;
    din_ready = '0;
`ifdef UP_CONV_ARB_ID_EN
    id_d      = id_q;
`endif
    if (cen) begin
      if (valid_q && dout_ready) valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            grant_d = pick;
            state_d = ST_GRANT;
          end
        end
        ST_GRANT: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            din_ready[i] = (grant_q == GRANT_WIDTH'(i)) & out_free;
          end
          if (sel_valid && out_free) begin
            dout_d  = sel_data;
            strb_d  = sel_strb;
            last_d  = sel_last;
            valid_d = 1'b1;
`ifdef UP_CONV_ARB_ID_EN
            id_d    = grant_q;
`endif
            if (sel_last) state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_WIDTH'(NUM_PORTS - 1);
      dout_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef UP_CONV_ARB_ID_EN
      id_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dout_q  <= dout_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef UP_CONV_ARB_ID_EN
      id_q    <= id_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_strb  = strb_q;
  assign dout_last  = last_q;
  assign dout_valid = valid_q;
  assign grant      = grant_q;
  assign busy       = (state_q == ST_GRANT);
`ifdef UP_CONV_ARB_ID_EN
  assign dout_id    = id_q;
`endif

endmodule

// File: tb/tb_up_conv_stream_arbiter.sv
// tb/tb_up_conv_stream_arbiter.sv - directed self-checking bench for up_conv_stream_arbiter
module tb_up_conv_stream_arbiter;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst, cen;
  logic [31:0]   din;
  logic [3:0]    din_strb, din_last, din_valid, din_ready;
  logic [7:0]    dout;
  logic [0:0]    dout_strb;
  logic          dout_last, dout_valid, dout_ready, busy;
  logic [1:0]    grant;
`ifdef UP_CONV_ARB_ID_EN
  logic [1:0]    dout_id;
`endif

  always #5 clk = ~clk;

  up_conv_stream_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .din        (din),
    .din_strb   (din_strb),
    .din_last   (din_last),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_strb  (dout_strb),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .grant      (grant),
`ifdef UP_CONV_ARB_ID_EN
    .dout_id    (dout_id),
`endif
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0] mem [NP][32];
  int         hd [NP];
  int         tl [NP];
  logic [3:0] src_en;

  int         hs_cyc [64];
  int         hs_port [64];
  int         n_hs;
  logic [8:0] out_log [64];
  int         n_out;

  logic       o_dv, o_last, o_busy, o_strb;
  logic [7:0] o_dout;
  logic [3:0] o_ready;
  logic [1:0] o_grant;

  logic [7:0] exp_t2 [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
  int         exp_p2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic l);
    mem[p][tl[p]] = {l, d};
    tl[p]++;
  endtask

  task automatic clear_env();
    for (int i = 0; i < NP; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    src_en = 4'b0000;
    n_hs   = 0;
    n_out  = 0;
  endtask

  // One clock: drive at the falling edge, sample just before the rising edge, log handshakes after it.
  task automatic run_cycle();
    logic [3:0] hs;
    logic       ohs;
    for (int i = 0; i < NP; i++) begin
      if (src_en[i] && hd[i] < tl[i]) begin
        din_valid[i]   = 1'b1;
        din[i*8 +: 8]  = mem[i][hd[i]][7:0];
        din_last[i]    = mem[i][hd[i]][8];
        din_strb[i]    = mem[i][hd[i]][0];
      end else begin
        din_valid[i]   = 1'b0;
        din[i*8 +: 8]  = 8'h00;
        din_last[i]    = 1'b0;
        din_strb[i]    = 1'b0;
      end
    end
    #1;
    o_dv    = dout_valid;
    o_dout  = dout;
    o_last  = dout_last;
    o_strb  = dout_strb[0];
    o_ready = din_ready;
    o_busy  = busy;
    o_grant = grant;
    hs  = din_valid & din_ready;
    ohs = dout_valid & dout_ready & cen;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        if (hs[i] && n_hs < 64) begin
          hd[i]++;
          hs_cyc[n_hs]  = cyc;
          hs_port[n_hs] = i;
          n_hs++;
        end
      end
      if (ohs && n_out < 64) begin
        out_log[n_out] = {o_last, o_dout};
        n_out++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_env();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cen = 1'b1; dout_ready = 1'b1;
    din = '0; din_strb = '0; din_last = '0; din_valid = '0;
    clear_env();
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout_last", dout_last, 1'b0);
    check("rst_dout_strb", dout_strb, 1'b0);
    check("rst_din_ready", din_ready, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 2'd3);

    // Single 3-beat packet on port 0
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    src_en = 4'b0001;
    run_cycle();
    check("t1_c0_ready", o_ready, 4'b0000);
    check("t1_c0_busy", o_busy, 1'b0);
    run_cycle();
    check("t1_c1_grant", o_grant, 2'd0);
    check("t1_c1_busy", o_busy, 1'b1);
    check("t1_c1_ready", o_ready, 4'b0001);
    check("t1_c1_dv", o_dv, 1'b0);
    run_cycle();
    check("t1_c2_dv", o_dv, 1'b1);
    check("t1_c2_dout", o_dout, 8'h11);
    check("t1_c2_strb", o_strb, 1'b1);
    check("t1_c2_last", o_last, 1'b0);
`ifdef UP_CONV_ARB_ID_EN
    check("t1_c2_id", dout_id, 2'd0);
`endif
    run_cycle();
    check("t1_c3_dout", o_dout, 8'h22);
    check("t1_c3_strb", o_strb, 1'b0);
    check("t1_c3_last", o_last, 1'b0);
    run_cycle();
    check("t1_c4_dout", o_dout, 8'h33);
    check("t1_c4_last", o_last, 1'b1);
    check("t1_c4_busy", o_busy, 1'b0);
    check("t1_c4_grant", o_grant, 2'd0);
    check("t1_c4_ready", o_ready, 4'b0000);
    run_cycle();
    check("t1_c5_dv", o_dv, 1'b0);
    check("t1_n_out", n_out, 3);

    // All ports continuously valid, 2-beat packets
    do_reset();
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    for (int p = 1; p < NP; p++) begin
      push(p, 8'(p * 16 + 1), 1'b0);
      push(p, 8'(p * 16 + 2), 1'b1);
    end
    src_en = 4'b1111;
    for (int k = 0; k < 18; k++) run_cycle();
    check("t2_n_hs", n_hs, 10);
    check("t2_n_out", n_out, 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t2_port_%0d", k), hs_port[k], exp_p2[k]);
      check($sformatf("t2_out_%0d", k), out_log[k], {1'(k % 2), exp_t2[k]});
      if (k > 0) check($sformatf("t2_gap_%0d", k), hs_cyc[k] - hs_cyc[k-1], (k % 2 == 1) ? 1 : 2);
    end

    // Output stall for 5 cycles mid-packet
    do_reset();
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b0); push(1, 8'h44, 1'b1);
    src_en = 4'b0010;
    for (int k = 0; k < 3; k++) run_cycle();
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      check($sformatf("t3_hold_dout_%0d", k), o_dout, 8'h42);
      check($sformatf("t3_hold_dv_%0d", k), o_dv, 1'b1);
      check($sformatf("t3_hold_ready_%0d", k), o_ready, 4'b0000);
    end
    dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) run_cycle();
    check("t3_n_hs", n_hs, 4);
    check("t3_n_out", n_out, 4);
    check("t3_out_0", out_log[0], 9'h041);
    check("t3_out_1", out_log[1], 9'h042);
    check("t3_out_2", out_log[2], 9'h043);
    check("t3_out_3", out_log[3], 9'h144);

    // Granted port 2 drops valid while port 1 requests
    do_reset();
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    push(1, 8'hB1, 1'b1);
    src_en = 4'b0100;
    run_cycle();
    run_cycle();
    src_en = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      check($sformatf("t4_grant_%0d", k), o_grant, 2'd2);
      check($sformatf("t4_busy_%0d", k), o_busy, 1'b1);
      check($sformatf("t4_ready_%0d", k), o_ready, 4'b0100);
    end
    src_en = 4'b0110;
    for (int k = 0; k < 10; k++) run_cycle();
    check("t4_n_out", n_out, 4);
    check("t4_out_0", out_log[0], 9'h0A1);
    check("t4_out_1", out_log[1], 9'h0A2);
    check("t4_out_2", out_log[2], 9'h1A3);
    check("t4_out_3", out_log[3], 9'h1B1);
    check("t4_port_3", hs_port[3], 1);

    // Clock enable low for 2 cycles mid-packet
    do_reset();
    push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b0); push(0, 8'hC3, 1'b1);
    src_en = 4'b0001;
    for (int k = 0; k < 3; k++) run_cycle();
    cen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      run_cycle();
      check($sformatf("t5_dout_%0d", k), o_dout, 8'hC2);
      check($sformatf("t5_dv_%0d", k), o_dv, 1'b1);
      check($sformatf("t5_ready_%0d", k), o_ready, 4'b0000);
      check($sformatf("t5_busy_%0d", k), o_busy, 1'b1);
      check($sformatf("t5_grant_%0d", k), o_grant, 2'd0);
    end
    cen = 1'b1;
    for (int k = 0; k < 6; k++) run_cycle();
    check("t5_n_hs", n_hs, 3);
    check("t5_n_out", n_out, 3);
    check("t5_out_0", out_log[0], 9'h0C1);
    check("t5_out_1", out_log[1], 9'h0C2);
    check("t5_out_2", out_log[2], 9'h1C3);

    // Reset mid-packet on port 3, then port 0 wins the next search
    do_reset();
    push(3, 8'hD1, 1'b0); push(3, 8'hD2, 1'b0); push(3, 8'hD3, 1'b1);
    src_en = 4'b1000;
    for (int k = 0; k < 3; k++) run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    check("t6_dout", dout, 8'h00);
    check("t6_dv", dout_valid, 1'b0);
    check("t6_last", dout_last, 1'b0);
    check("t6_strb", dout_strb, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_grant", grant, 2'd3);
    check("t6_ready", din_ready, 4'b0000);
    clear_env();
    push(0, 8'hE1, 1'b1);
    push(3, 8'hF1, 1'b1);
    src_en = 4'b1001;
    run_cycle();
    run_cycle();
    check("t6_next_grant", o_grant, 2'd0);
    for (int k = 0; k < 6; k++) run_cycle();
    check("t6_n_hs", n_hs, 2);
    check("t6_port_0", hs_port[0], 0);
    check("t6_port_1", hs_port[1], 3);
    check("t6_out_0", out_log[0], 9'h1E1);
    check("t6_out_1", out_log[1], 9'h1F1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
